// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - boot-time byte-stream loader for instruction memory
// Streams bytes into memory from BOOT_ADDR and holds the core in reset until the image is complete.
module imem_program_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] BOOT_ADDR  = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  loadStart_i,
    input  logic [ADDR_WIDTH:0]   loadLength_i,
    input  logic                  bootNow_i,
    input  logic                  loadAbort_i,
    input  logic                  byteValid_i,
    input  logic [7:0]            byteData_i,
    output logic                  byteReady_o,
    output logic                  memWriteEnable_o,
    output logic [31:0]           memWriteAddress_o,
    output logic [7:0]            memWriteData_o,
    output logic                  cpuReset_o,
    output logic                  busy_o,
    output logic                  loadDone_o,
    output logic                  loadError_o,
    output logic [7:0]            checksum_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  error_q, error_d;
    logic [7:0]            checksum_q, checksum_d;
    logic                  len_legal;

    assign len_legal = (loadLength_i != '0) && (loadLength_i <= MAX_LEN);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            data_q      <= 8'h0;
            cpu_reset_q <= 1'b1;
            error_q     <= 1'b0;
            checksum_q  <= 8'h0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            error_q     <= error_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        error_d    = error_q;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE, S_RUN: begin
                // loadStart has priority over bootNow; RUN ignores bootNow entirely
                if (loadStart_i) begin
                    if (len_legal) begin
                        state_d    = S_LOAD;
                        len_d      = loadLength_i;
                        count_d    = '0;
                        checksum_d = 8'h0;
                        error_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end else if (bootNow_i && state_q == S_IDLE) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                // An abort beats a same-cycle byte: that byte is neither written nor counted
                if (loadAbort_i) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (byteValid_i) begin
                    we_d       = 1'b1;
                    addr_d     = BOOT_ADDR + 32'(count_q);
                    data_d     = byteData_i;
                    count_d    = count_q + ONE;
                    checksum_d = checksum_q + byteData_i;
                    if (count_q == len_q - ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_reset_d = (state_d != S_RUN);
    end

    assign byteReady_o       = (state_q == S_LOAD);
    assign busy_o            = (state_q == S_LOAD) || (state_q == S_DONE);
    assign loadDone_o        = (state_q == S_DONE);
    assign memWriteEnable_o  = we_q;
    assign memWriteAddress_o = addr_q;
    assign memWriteData_o    = data_q;
    assign cpuReset_o        = cpu_reset_q;
    assign loadError_o       = error_q;
    assign checksum_o        = checksum_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - randomized self-checking bench for imem_program_loader
// Expected writes and checksums come from the image bytes themselves (address BOOT+i, sum mod 256).
module tb_imem_program_loader;

    localparam int          AW   = 4;
    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam int          MAXL = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          loadStart;
    logic [AW:0]   loadLength;
    logic          bootNow;
    logic          loadAbort;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          byteReady;
    logic          memWriteEnable;
    logic [31:0]   memWriteAddress;
    logic [7:0]    memWriteData;
    logic          cpuReset;
    logic          busy;
    logic          loadDone;
    logic          loadError;
    logic [7:0]    checksum;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    img [MAXL];
    logic [7:0]    last_sum;
    logic [31:0]   wr_addr_q [$];
    logic [7:0]    wr_data_q [$];

    imem_program_loader #(
        .ADDR_WIDTH (AW),
        .BOOT_ADDR  (BOOT)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .loadStart_i       (loadStart),
        .loadLength_i      (loadLength),
        .bootNow_i         (bootNow),
        .loadAbort_i       (loadAbort),
        .byteValid_i       (byteValid),
        .byteData_i        (byteData),
        .byteReady_o       (byteReady),
        .memWriteEnable_o  (memWriteEnable),
        .memWriteAddress_o (memWriteAddress),
        .memWriteData_o    (memWriteData),
        .cpuReset_o        (cpuReset),
        .busy_o            (busy),
        .loadDone_o        (loadDone),
        .loadError_o       (loadError),
        .checksum_o        (checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWriteEnable) begin
            wr_addr_q.push_back(memWriteAddress);
            wr_data_q.push_back(memWriteData);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) img[i] = 8'($urandom);
    endtask

    // Runs one load from IDLE or RUN; abort_at < 0 means no abort.
    task automatic run_load(input int len, input int maxgap, input int abort_at);
        logic [7:0] sum;
        int         n_exp;
        sum = 8'h0;
        wr_addr_q.delete();
        wr_data_q.delete();
        loadStart  = 1'b1;
        loadLength = len[AW:0];
        bootNow    = 1'($urandom_range(0, 1));
        step();
        loadStart = 1'b0;
        bootNow   = 1'b0;
        check("load_ready", byteReady, 1);
        check("load_err_clr", loadError, 0);
        check("load_cpurst", cpuReset, 1);
        check("load_busy", busy, 1);
        check("load_cksum_clr", checksum, 0);
        n_exp = (abort_at >= 0) ? abort_at : len;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                byteValid  = 1'b0;
                byteData   = 8'($urandom);
                loadStart  = 1'($urandom_range(0, 1));
                loadLength = 5'($urandom_range(1, MAXL));
                bootNow    = 1'($urandom_range(0, 1));
                step();
                check("gap_no_write", memWriteEnable, 0);
            end
            loadStart = 1'b0;
            bootNow   = 1'b0;
            byteValid = 1'b1;
            byteData  = img[i];
            loadAbort = (i == abort_at);
            step();
            byteValid = 1'b0;
            loadAbort = 1'b0;
            if (i == abort_at) break;
            sum = sum + img[i];
            check("wr_strobe", memWriteEnable, 1);
            check("wr_addr", memWriteAddress, BOOT + 32'(i));
            check("wr_data", memWriteData, img[i]);
            check("done_timing", loadDone, (i == len - 1) ? 1 : 0);
        end
        if (abort_at >= 0) begin
            check("abort_ready", byteReady, 0);
            check("abort_err", loadError, 1);
            check("abort_cpurst", cpuReset, 1);
            check("abort_busy", busy, 0);
            check("abort_no_write", memWriteEnable, 0);
            step();
            check("abort_nwrites", wr_addr_q.size(), n_exp);
            check("abort_idle_cpurst", cpuReset, 1);
        end else begin
            check("done_ready", byteReady, 0);
            check("done_cpurst", cpuReset, 1);
            check("done_busy", busy, 1);
            check("done_cksum", checksum, sum);
            loadAbort = 1'b1;
            step();
            loadAbort = 1'b0;
            check("run_cpurst", cpuReset, 0);
            check("run_done_low", loadDone, 0);
            check("run_busy", busy, 0);
            check("run_err", loadError, 0);
            check("run_cksum", checksum, sum);
            check("nwrites", wr_addr_q.size(), n_exp);
            for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
                check("q_addr", wr_addr_q[i], BOOT + 32'(i));
                check("q_data", wr_data_q[i], img[i]);
            end
            last_sum = sum;
        end
    endtask

    initial begin
        reset      = 1'b1;
        loadStart  = 1'b0;
        loadLength = '0;
        bootNow    = 1'b0;
        loadAbort  = 1'b0;
        byteValid  = 1'b0;
        byteData   = 8'h0;
        last_sum   = 8'h0;
        #2;
        check("rst_cpurst", cpuReset, 1);
        check("rst_we", memWriteEnable, 0);
        check("rst_addr", memWriteAddress, 0);
        check("rst_data", memWriteData, 0);
        check("rst_ready", byteReady, 0);
        check("rst_busy", busy, 0);
        check("rst_done", loadDone, 0);
        check("rst_err", loadError, 0);
        check("rst_cksum", checksum, 0);
        step();
        step();
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_cpurst", cpuReset, 1);
            check("idle_ready", byteReady, 0);
            check("idle_we", memWriteEnable, 0);
        end

        // Illegal lengths in IDLE: both below and above the legal range
        loadStart  = 1'b1;
        loadLength = 5'd0;
        step();
        loadStart = 1'b0;
        check("len0_err", loadError, 1);
        check("len0_ready", byteReady, 0);
        check("len0_cpurst", cpuReset, 1);
        loadStart  = 1'b1;
        loadLength = 5'(MAXL + 1);
        step();
        loadStart = 1'b0;
        check("lenbig_ready", byteReady, 0);
        check("lenbig_err", loadError, 1);
        check("lenbig_busy", busy, 0);

        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        run_load(4, 0, -1);

        fill_random(3);
        run_load(3, 2, -1);

        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, MAXL);
            fill_random(len);
            run_load(len, $urandom_range(0, 3), -1);
        end

        fill_random(MAXL);
        run_load(MAXL, 1, -1);
        fill_random(1);
        run_load(1, 0, -1);

        // Illegal length from RUN drops back to IDLE with error, checksum kept
        loadStart  = 1'b1;
        loadLength = 5'd0;
        step();
        loadStart = 1'b0;
        check("run_ill_err", loadError, 1);
        check("run_ill_cpurst", cpuReset, 1);
        check("run_ill_cksum", checksum, last_sum);
        step();
        check("run_ill_idle", byteReady, 0);

        fill_random(4);
        run_load(4, 1, 1);

        bootNow = 1'b1;
        step();
        bootNow = 1'b0;
        check("boot_cpurst", cpuReset, 0);
        check("boot_ready", byteReady, 0);
        check("boot_busy", busy, 0);
        bootNow   = 1'b1;
        loadAbort = 1'b1;
        step();
        bootNow   = 1'b0;
        loadAbort = 1'b0;
        check("run_ignore_cpurst", cpuReset, 0);
        check("run_ignore_err", loadError, 1);

        fill_random(5);
        run_load(5, 2, -1);

        // Asynchronous reset between edges during a load
        loadStart  = 1'b1;
        loadLength = 5'd8;
        step();
        loadStart = 1'b0;
        byteValid = 1'b1;
        byteData  = 8'h5a;
        step();
        step();
        byteValid = 1'b0;
        check("pre_arst_we", memWriteEnable, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", memWriteEnable, 0);
        check("arst_ready", byteReady, 0);
        check("arst_cpurst", cpuReset, 1);
        check("arst_cksum", checksum, 0);
        check("arst_addr", memWriteAddress, 0);
        check("arst_busy", busy, 0);
        #2;
        reset = 1'b0;
        step();
        check("post_arst_ready", byteReady, 0);
        check("post_arst_we", memWriteEnable, 0);
        check("post_arst_cpurst", cpuReset, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
